// File: rtl/mips16_isa_pkg.sv
// Shared ISA constants for the 16-bit MIPS pipeline front end and decode.
// The fetch stage and data_dependency_block both import this package so the
// opcode encodings live in exactly one place.
package mips16_isa_pkg;

    localparam logic [5:0]  OP_JMP       = 6'b011000;
    localparam logic [5:0]  OP_LD        = 6'b010100;
    localparam logic [5:0]  OP_ST        = 6'b010101;
    localparam logic [3:0]  OP_CJ_PREFIX = 4'b0111;
    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

    // Fetch state; the encoding is also what cond_wait reflects.
    typedef enum logic {
        FETCH_RUN       = 1'b0,
        FETCH_COND_WAIT = 1'b1
    } fetch_state_e;

    function automatic logic is_jmp(input logic [5:0] op);
        return op == OP_JMP;
    endfunction

    function automatic logic is_ld(input logic [5:0] op);
        return op == OP_LD;
    endfunction

    function automatic logic is_st(input logic [5:0] op);
        return op == OP_ST;
    endfunction

    // Conditional jumps occupy the whole 0111xx opcode group.
    function automatic logic is_cj(input logic [5:0] op);
        return op[5:2] == OP_CJ_PREFIX;
    endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: one write port, one synchronous read port.
// A read and write to the same address in the same cycle returns the old
// word. Contents are not reset; the program is loaded through the write port.
module instr_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Write port: the new word lands at the clock edge.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: sampled before the write of the same edge, so a collision
    // yields the old word. Data holds while i_re is low.
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Front end of the 16-bit MIPS pipeline. Holds the PC, reads instruction
// memory and presents one instruction word per cycle to decode. Control flow
// is resolved here by decoding the word currently on ins: JMP and LD each
// insert one NOP bubble, a conditional jump parks fetch in COND_WAIT until
// execute reports the outcome.
//
// Handshake: there is no valid/ready pair. stall_in freezes ins, ins_pc, pc
// and state; cond_valid_in is a one-cycle pulse qualifying cond_taken_in and
// is only meaningful in COND_WAIT, where it is honoured even while stalled.
module instruction_fetch_stage
    import mips16_isa_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_in,
    input  logic              cond_valid_in,
    input  logic              cond_taken_in,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [31:0]       imem_wdata,
    output logic [31:0]       ins,
    output logic [ADDR_W-1:0] ins_pc,
    output logic              cond_wait
);

    fetch_state_e      r_state;
    fetch_state_e      w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_ins_pc;
    logic [ADDR_W-1:0] r_target;
    // The ins register is the memory read register plus this flag: when set,
    // the word on ins is a NOP regardless of what the read register holds.
    logic              r_ins_nop;

    logic [31:0]       w_mem_rdata;
    logic [31:0]       w_ins;
    logic [5:0]        w_opcode;
    logic [ADDR_W-1:0] w_ins_target;
    logic              w_is_jmp;
    logic              w_is_ld;
    logic              w_is_cj;
    logic              w_run_go;
    logic              w_fetch;
    logic              w_resolve;

    assign w_ins        = r_ins_nop ? NOP_WORD : w_mem_rdata;
    assign w_opcode     = w_ins[31:26];
    assign w_ins_target = w_ins[ADDR_W-1:0];
    assign w_is_jmp     = is_jmp(w_opcode);
    assign w_is_ld      = is_ld(w_opcode);
    assign w_is_cj      = is_cj(w_opcode);

    // RUN and not stalled: the word on ins is acted upon this edge.
    assign w_run_go  = (r_state == FETCH_RUN) && !stall_in;
    // A real fetch only happens when ins carries no control-flow effect.
    assign w_fetch   = w_run_go && !(w_is_jmp || w_is_ld || w_is_cj);
    // Outcome arrives while waiting; stall does not block it.
    assign w_resolve = (r_state == FETCH_COND_WAIT) && cond_valid_in;

    instr_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (32)
    ) u_imem (
        .i_clk   (clk),
        .i_we    (imem_we),
        .i_waddr (imem_waddr),
        .i_wdata (imem_wdata),
        .i_re    (w_fetch),
        .i_raddr (r_pc),
        .o_rdata (w_mem_rdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: enter COND_WAIT on an acted-upon CJ, leave on its outcome.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH_RUN: begin
                if (w_run_go && w_is_cj) begin
                    w_state_next = FETCH_COND_WAIT;
                end
            end
            FETCH_COND_WAIT: begin
                if (cond_valid_in) begin
                    w_state_next = FETCH_RUN;
                end
            end
            default: w_state_next = FETCH_RUN;
        endcase
    end

    // State-derived outputs.
    always_comb begin
        cond_wait = 1'b0;
        if (r_state == FETCH_COND_WAIT) begin
            cond_wait = 1'b1;
        end
    end

    // PC, jump target latch, ins_pc and the NOP flag of the ins register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_ins_pc  <= RESET_PC;
            r_target  <= '0;
            r_ins_nop <= 1'b1;
        end else begin
            if (w_resolve) begin
                // pc already points at CJ+1, so not-taken leaves it alone.
                if (cond_taken_in) begin
                    r_pc <= r_target;
                end
            end else if (w_run_go) begin
                if (w_is_jmp) begin
                    r_pc <= w_ins_target;
                end else if (w_fetch) begin
                    r_pc <= r_pc + ADDR_W'(1);
                end
            end

            if (w_run_go && w_is_cj) begin
                r_target <= w_ins_target;
            end

            // NOP slots carry the pc of the slot that was skipped.
            if (!stall_in) begin
                r_ins_pc  <= r_pc;
                r_ins_nop <= !w_fetch;
            end
        end
    end

    assign ins    = w_ins;
    assign ins_pc = r_ins_pc;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios with fixed expected
// sequences, then randomized traffic checked every cycle against a reference
// model of the fetch rules. A second instance with a 4-bit PC covers wrap.
module tb_instruction_fetch_stage;

    localparam int AW = 8;
    localparam logic [31:0] NOP = 32'h0000_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset = 1'b1;
    logic          stall_in = 1'b0;
    logic          cond_valid_in = 1'b0;
    logic          cond_taken_in = 1'b0;
    logic          imem_we = 1'b0;
    logic [AW-1:0] imem_waddr = '0;
    logic [31:0]   imem_wdata = '0;
    logic [31:0]   ins;
    logic [AW-1:0] ins_pc;
    logic          cond_wait;

    logic          reset4 = 1'b1;
    logic          zero4 = 1'b0;
    logic          we4 = 1'b0;
    logic [3:0]    waddr4 = '0;
    logic [31:0]   wdata4 = '0;
    logic [31:0]   ins4;
    logic [3:0]    ins_pc4;
    logic          cond_wait4;

    instruction_fetch_stage #(.ADDR_W(AW), .RESET_PC('0)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .stall_in      (stall_in),
        .cond_valid_in (cond_valid_in),
        .cond_taken_in (cond_taken_in),
        .imem_we       (imem_we),
        .imem_waddr    (imem_waddr),
        .imem_wdata    (imem_wdata),
        .ins           (ins),
        .ins_pc        (ins_pc),
        .cond_wait     (cond_wait)
    );

    instruction_fetch_stage #(.ADDR_W(4), .RESET_PC(4'd15)) u_dut4 (
        .clk           (clk),
        .reset         (reset4),
        .stall_in      (zero4),
        .cond_valid_in (zero4),
        .cond_taken_in (zero4),
        .imem_we       (we4),
        .imem_waddr    (waddr4),
        .imem_wdata    (wdata4),
        .ins           (ins4),
        .ins_pc        (ins_pc4),
        .cond_wait     (cond_wait4)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Program-level view: which word is issued next, given the word just
    // issued, the pending-jump flag and the memory image.
    logic [31:0]   m_mem [256];
    logic [31:0]   m_ins;
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_ins_pc;
    logic [AW-1:0] m_tgt;
    logic          m_wait;

    task automatic model_step();
        logic [5:0] op;
        if (reset) begin
            m_ins    = NOP;
            m_pc     = '0;
            m_ins_pc = '0;
            m_tgt    = '0;
            m_wait   = 1'b0;
        end else if (m_wait) begin
            m_ins = NOP;
            if (cond_valid_in) begin
                if (cond_taken_in) m_pc = m_tgt;
                m_wait = 1'b0;
            end
        end else if (!stall_in) begin
            op = m_ins[31:26];
            if (op == 6'b011000) begin
                m_pc  = m_ins[AW-1:0];
                m_ins = NOP;
            end else if (op == 6'b010100) begin
                m_ins = NOP;
            end else if (op[5:2] == 4'b0111) begin
                m_tgt  = m_ins[AW-1:0];
                m_wait = 1'b1;
                m_ins  = NOP;
            end else begin
                m_ins    = m_mem[m_pc];
                m_ins_pc = m_pc;
                m_pc     = m_pc + 8'd1;
            end
        end
        if (imem_we) m_mem[imem_waddr] = imem_wdata;
    endtask

    // ---------------- driver tasks ----------------
    // One clock: model advances on the edge, outputs are compared on the
    // falling edge, one-cycle pulses are cleared afterwards.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_ins", ins, m_ins);
        check("model_cond_wait", 32'(cond_wait), 32'(m_wait));
        if (m_ins != NOP) check("model_ins_pc", 32'(ins_pc), 32'(m_ins_pc));
        imem_we       = 1'b0;
        cond_valid_in = 1'b0;
        we4           = 1'b0;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [31:0] w);
        reset      = 1'b1;
        imem_we    = 1'b1;
        imem_waddr = a;
        imem_wdata = w;
        cycle();
    endtask

    task automatic seq_check(input string tag, input logic [31:0] w, input int pc);
        check({tag, "_ins"}, ins, w);
        if (pc >= 0) check({tag, "_pc"}, 32'(ins_pc), 32'(pc));
    endtask

    function automatic logic [31:0] alu(input int n);
        return 32'h0800_0000 + 32'(n);
    endfunction

    function automatic logic [31:0] jmp(input logic [7:0] t);
        return {6'b011000, 18'h0, t};
    endfunction

    function automatic logic [31:0] ldw(input int n);
        return {6'b010100, 26'(n)};
    endfunction

    function automatic logic [31:0] cjw(input logic [7:0] t);
        return {6'b011101, 18'h0, t};
    endfunction

    function automatic logic [31:0] rand_word();
        int          sel;
        logic [31:0] r;
        sel = $urandom_range(0, 9);
        r   = $urandom();
        case (sel)
            0:       return {6'b011000, r[25:0]};
            1:       return {6'b010100, r[25:0]};
            2:       return {4'b0111, r[27:0]};
            default: return {2'b00, r[29:0]};
        endcase
    endfunction

    task automatic prog_base();
        for (int i = 0; i < 8; i++) load(AW'(i), alu(i));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int wcnt;
        logic [31:0] new_word;

        // Reset state and wrap on the 4-bit instance.
        cycle();
        seq_check("reset", NOP, 0);
        check("reset_cond_wait", 32'(cond_wait), 32'd0);
        we4 = 1'b1; waddr4 = 4'd15; wdata4 = alu(15); cycle();
        we4 = 1'b1; waddr4 = 4'd0;  wdata4 = alu(40); cycle();
        we4 = 1'b1; waddr4 = 4'd1;  wdata4 = alu(41); cycle();
        check("wrap_reset_ins", ins4, NOP);
        check("wrap_reset_pc", 32'(ins_pc4), 32'd15);
        reset4 = 1'b0;
        cycle();
        check("wrap_ins15", ins4, alu(15));
        check("wrap_pc15", 32'(ins_pc4), 32'd15);
        cycle();
        check("wrap_ins0", ins4, alu(40));
        check("wrap_pc0", 32'(ins_pc4), 32'd0);
        cycle();
        check("wrap_ins1", ins4, alu(41));
        check("wrap_cond_wait", 32'(cond_wait4), 32'd0);
        reset4 = 1'b1;

        // Whole memory known before directed work.
        for (int a = 0; a < 256; a++) load(AW'(a), alu(a + 32'h100));

        // Sequential fetch.
        prog_base();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            seq_check("seq", alu(i), i);
        end

        // JMP: one bubble, jump+1 never issued.
        prog_base();
        load(8'd2, jmp(8'h10));
        load(8'h10, alu(8'h10));
        reset = 1'b0;
        cycle(); seq_check("jmp_w0", alu(0), 0);
        cycle(); seq_check("jmp_w1", alu(1), 1);
        cycle(); seq_check("jmp_jmp", jmp(8'h10), 2);
        cycle(); seq_check("jmp_bubble", NOP, -1);
        cycle(); seq_check("jmp_target", alu(8'h10), 8'h10);

        // LD bubbles, back to back.
        prog_base();
        load(8'd1, ldw(1));
        load(8'd2, ldw(2));
        reset = 1'b0;
        cycle(); seq_check("ld_w0", alu(0), 0);
        cycle(); seq_check("ld_ld1", ldw(1), 1);
        cycle(); seq_check("ld_bub1", NOP, -1);
        cycle(); seq_check("ld_ld2", ldw(2), 2);
        cycle(); seq_check("ld_bub2", NOP, -1);
        cycle(); seq_check("ld_w3", alu(3), 3);

        // Conditional jump, taken then not taken.
        for (int t = 1; t >= 0; t--) begin
            prog_base();
            load(8'd4, cjw(8'h20));
            load(8'h20, alu(8'h20));
            reset = 1'b0;
            for (int i = 0; i < 4; i++) cycle();
            cycle(); seq_check("cj_word", cjw(8'h20), 4);
            wcnt = 0;
            for (int k = 0; k < 3; k++) begin
                cycle();
                seq_check("cj_bubble", NOP, -1);
                wcnt += int'(cond_wait);
            end
            cond_valid_in = 1'b1;
            cond_taken_in = (t == 1);
            cycle();
            seq_check("cj_bubble_last", NOP, -1);
            wcnt += int'(cond_wait);
            check("cj_wait_cycles", 32'(wcnt), 32'd3);
            cycle();
            if (t == 1) seq_check("cj_taken", alu(8'h20), 8'h20);
            else        seq_check("cj_not_taken", alu(5), 5);
        end

        // Stall during RUN.
        prog_base();
        reset = 1'b0;
        cycle(); cycle();
        stall_in = 1'b1;
        cycle(); seq_check("stall_hold1", alu(1), 1);
        cycle(); seq_check("stall_hold2", alu(1), 1);
        stall_in = 1'b0;
        cycle(); seq_check("stall_resume", alu(2), 2);

        // Resolution during a stall in COND_WAIT is not lost.
        prog_base();
        load(8'd4, cjw(8'h20));
        load(8'h20, alu(8'h20));
        reset = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        cycle();
        check("stall_cw_wait", 32'(cond_wait), 32'd1);
        stall_in      = 1'b1;
        cond_valid_in = 1'b1;
        cond_taken_in = 1'b1;
        cycle();
        seq_check("stall_cw_nop", NOP, -1);
        check("stall_cw_left", 32'(cond_wait), 32'd0);
        cycle();
        seq_check("stall_cw_hold", NOP, -1);
        stall_in = 1'b0;
        cycle();
        seq_check("stall_cw_target", alu(8'h20), 8'h20);

        // Read/write collision returns the old word, write still lands.
        prog_base();
        reset = 1'b0;
        cycle(); cycle();
        new_word   = 32'h0BAD_0002;
        imem_we    = 1'b1;
        imem_waddr = 8'd2;
        imem_wdata = new_word;
        cycle();
        seq_check("collide_old", alu(2), 2);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle(); cycle(); cycle();
        seq_check("collide_new", new_word, 2);

        // Reset in COND_WAIT aborts immediately.
        prog_base();
        load(8'd4, cjw(8'h20));
        reset = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        cycle();
        check("rst_cw_wait", 32'(cond_wait), 32'd1);
        reset = 1'b1;
        cycle();
        seq_check("rst_cw_nop", NOP, -1);
        check("rst_cw_cleared", 32'(cond_wait), 32'd0);
        reset = 1'b0;
        cycle();
        seq_check("rst_cw_restart", alu(0), 0);

        // Randomized traffic against the model.
        for (int a = 0; a < 256; a++) load(AW'(a), rand_word());
        reset = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            reset         = ($urandom_range(0, 99) < 1);
            stall_in      = ($urandom_range(0, 99) < 15);
            cond_valid_in = ($urandom_range(0, 99) < 30);
            cond_taken_in = 1'($urandom_range(0, 1));
            imem_we       = ($urandom_range(0, 99) < 10);
            imem_waddr    = ($urandom_range(0, 1) == 1) ? m_pc : AW'($urandom_range(0, 255));
            imem_wdata    = rand_word();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
